// File: rtl/alu_seq_exec_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_exec_if
// Purpose  : Bundles the request/response signals of the sequential ALU.
//            Member names carry the DUT's point of view: i_* members are
//            driven by the requester, o_* members are driven by the ALU.
// Ports    : i_start      - request to execute one operation
//            i_alu_ctrl   - 4-bit operation code
//            i_src_a      - first operand (WIDTH bits)
//            i_src_b      - second operand (WIDTH bits)
//            o_busy       - operation accepted and not yet retired
//            o_done       - one-cycle pulse, result fields valid
//            o_alu_result - registered result (WIDTH bits)
//            o_zero       - registered result-is-zero flag
//            o_illegal_op - registered unknown-opcode flag
// Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_exec_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [3:0]       i_alu_ctrl;
  logic [WIDTH-1:0] i_src_a;
  logic [WIDTH-1:0] i_src_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_alu_result;
  logic             o_zero;
  logic             o_illegal_op;

  modport master (
    output i_start, i_alu_ctrl, i_src_a, i_src_b,
    input  o_busy, o_done, o_alu_result, o_zero, o_illegal_op
  );

  modport slave (
    input  i_start, i_alu_ctrl, i_src_a, i_src_b,
    output o_busy, o_done, o_alu_result, o_zero, o_illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_exec
// Purpose  : Multi-cycle ALU. Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR)
//            retire one edge after acceptance; MUL is a bit-serial
//            shift-and-add taking WIDTH further edges.
// Ports    : clk - rising-edge clock
//            rst - synchronous active-high reset
//            bus - alu_seq_exec_if.slave (start/opcode/operands in,
//                  busy/done/result/zero/illegal out)
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_exec #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_exec_if.slave  bus
);
  // Counter holds 0..WIDTH so the final increment never wraps.
  localparam int              CW          = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   c_LAST_STEP = CW'(WIDTH - 1);

  localparam logic [3:0] c_OP_AND = 4'b0000;
  localparam logic [3:0] c_OP_OR  = 4'b0001;
  localparam logic [3:0] c_OP_ADD = 4'b0010;
  localparam logic [3:0] c_OP_SUB = 4'b0110;
  localparam logic [3:0] c_OP_SLT = 4'b0111;
  localparam logic [3:0] c_OP_NOR = 4'b1100;
  localparam logic [3:0] c_OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_zero;
  logic             r_illegal;

  logic [WIDTH-1:0] w_alu_res;
  logic             w_illegal;
  logic [WIDTH-1:0] w_acc_next;

  // Single-cycle datapath, evaluated on the live inputs; its result is only
  // captured on the accepting edge, which is what latches the operands.
  always_comb begin
    w_alu_res = '0;
    w_illegal = 1'b0;
    case (bus.i_alu_ctrl)
      c_OP_AND: w_alu_res = bus.i_src_a & bus.i_src_b;
      c_OP_OR:  w_alu_res = bus.i_src_a | bus.i_src_b;
      c_OP_ADD: w_alu_res = bus.i_src_a + bus.i_src_b;
      c_OP_SUB: w_alu_res = bus.i_src_a - bus.i_src_b;
      c_OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}},
                             ($signed(bus.i_src_a) < $signed(bus.i_src_b))};
      c_OP_NOR: w_alu_res = ~(bus.i_src_a | bus.i_src_b);
      c_OP_MUL: w_alu_res = '0;
      default:  w_illegal = 1'b1;
    endcase
  end

  // One multiplier bit per step: the multiplicand walks left while the
  // multiplier walks right, so bit 0 is always the bit being consumed.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_busy <= 1'b1;
            if (bus.i_alu_ctrl == c_OP_MUL) begin
              r_mcand  <= bus.i_src_a;
              r_mplier <= bus.i_src_b;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= S_MUL;
            end else begin
              r_result  <= w_alu_res;
              r_zero    <= (w_alu_res == '0);
              r_illegal <= w_illegal;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == c_LAST_STEP) begin
            r_result  <= w_acc_next;
            r_zero    <= (w_acc_next == '0);
            r_illegal <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_alu_result = r_result;
  assign bus.o_zero       = r_zero;
  assign bus.o_illegal_op = r_illegal;

endmodule
`default_nettype wire

// File: doc/alu_seq_exec.md
ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous active-high reset, sampled on Clock rising edge.
REQ-004 Start  input  1  request to execute one operation; sampled only when Busy=0.
REQ-005 ALUCtrl  input  4  operation code, same encoding the decode stage produces (see REQ-010).
REQ-006 SrcA  input  WIDTH  first operand.
REQ-007 SrcB  input  WIDTH  second operand.
REQ-008 Busy  output  1  high while an accepted operation is not yet retired (state != IDLE).
REQ-009 Done  output  1  single-cycle pulse marking ALUResult, Zero and IllegalOp valid for the just-finished operation.
REQ-010 ALUResult  output  WIDTH  registered result.
REQ-011 Zero  output  1  registered, 1 iff the registered ALUResult equals 0.
REQ-012 IllegalOp  output  1  registered, 1 iff the retired ALUCtrl code is not in REQ-014.

Function
REQ-013 States SHALL be IDLE, MUL, DONE; Busy=1 in MUL and DONE.
REQ-014 Codes: 0000 AND; 0001 OR; 0010 ADD (mod 2^WIDTH); 0110 SUB (SrcA-SrcB mod 2^WIDTH); 0111 SLT (signed, result 1 or 0); 1100 NOR; 1000 MUL (low WIDTH bits of unsigned product).
REQ-015 In IDLE with Start=1 at edge E0: SrcA, SrcB, ALUCtrl SHALL be latched; later input changes SHALL have no effect on that operation.
REQ-016 Non-MUL code accepted at E0: result, Zero, IllegalOp registered at E0; state -> DONE; Done=1 for the cycle after E0 (latency 1).
REQ-017 Illegal code: ALUResult=0, Zero=1, IllegalOp=1, same timing as REQ-016.
REQ-018 MUL accepted at E0: state -> MUL, accumulator=0, iteration count=0; edges E0+1..E0+WIDTH each perform one shift-and-add step on one multiplier bit (LSB first).
REQ-019 At edge E0+WIDTH the product SHALL be written to ALUResult and state -> DONE; Done=1 for that following cycle; latency WIDTH cycles from acceptance to Done.
REQ-020 Iteration counter SHALL be wide enough for WIDTH and SHALL not wrap during an operation.
REQ-021 DONE -> IDLE unconditionally on next edge; Done SHALL never be high two consecutive cycles.
REQ-022 Start while Busy=1 SHALL be ignored (not queued); earliest next acceptance is the edge ending the first IDLE cycle after Done.
REQ-023 ALUResult, Zero, IllegalOp SHALL hold their values between Done pulses; they SHALL change only at retirement edges.
REQ-024 Overflow in ADD, SUB, MUL SHALL wrap silently; no flag.

Reset
REQ-025 Reset=1 at an edge SHALL force IDLE, Busy=0, Done=0, ALUResult=0, Zero=0, IllegalOp=0, accumulator and counter cleared.
REQ-026 Reset SHALL take priority over Start in the same cycle; that Start SHALL not be accepted.
REQ-027 Reset during MUL or DONE SHALL abort the operation with no Done pulse.

Verification
REQ-028 ADD: SrcA=5, SrcB=7, ALUCtrl=0010, Start pulse -> Done next cycle, ALUResult=12, Zero=0, IllegalOp=0; Busy high exactly 1 cycle.
REQ-029 SUB/SLT: SrcA=3, SrcB=3, 0110 -> ALUResult=0, Zero=1; then SrcA=0xFFFFFFFF, SrcB=1, 0111 -> ALUResult=1.
REQ-030 MUL: SrcA=0x00010001, SrcB=0x00000003, 1000 -> Done exactly 32 cycles after acceptance, ALUResult=0x00030003; operands changed during MUL do not alter result; Start during MUL ignored.
REQ-031 MUL wrap: SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> ALUResult=0x00000001.
REQ-032 Illegal: ALUCtrl=1111 -> Done next cycle, ALUResult=0, Zero=1, IllegalOp=1; following legal op clears IllegalOp.
REQ-033 Reset at cycle 10 of a MUL -> next cycle Busy=0, all outputs 0, no Done; Start asserted together with Reset not accepted; new ADD afterwards completes normally.
